// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// The result is computed at accept time and parked in temps until the busy period ends.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        keep;   // divide by zero: leave hi/lo untouched at commit
  } res_t;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  res_t        res_q, res_d;
  logic        accept, commit;

  // Single 64-bit multiplier: sign- or zero-extend by op, keep the low 64 bits.
  logic        ext_a, ext_b;
  logic [63:0] prod;

  assign ext_a = (op == OP_MULT) & rs_data[31];
  assign ext_b = (op == OP_MULT) & rt_data[31];
  assign prod  = {{32{ext_a}}, rs_data} * {{32{ext_b}}, rt_data};

  // Signed divide is done on magnitudes, then signs are restored.
  logic        sdiv, a_neg, b_neg, dz;
  logic [31:0] dvd, dvs, dvs_safe, uq, ur, quo, rem;

  assign sdiv     = (op == OP_DIV);
  assign a_neg    = sdiv & rs_data[31];
  assign b_neg    = sdiv & rt_data[31];
  assign dz       = (rt_data == 32'd0);
  assign dvd      = a_neg ? -rs_data : rs_data;
  assign dvs      = b_neg ? -rt_data : rt_data;
  assign dvs_safe = dz ? 32'd1 : dvs;
  assign uq       = dvd / dvs_safe;
  assign ur       = dvd % dvs_safe;
  assign quo      = (a_neg ^ b_neg) ? -uq : uq;
  assign rem      = a_neg ? -ur : ur;

  assign accept = start && (state_q == IDLE);
  assign busy   = (state_q == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = 5'(MULT_CYCLES);
              res_d   = '{hi: prod[63:32], lo: prod[31:0], keep: 1'b0};
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = 5'(DIV_CYCLES);
              res_d   = '{hi: rem, lo: quo, keep: dz};
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!res_q.keep) begin
        hi <= res_q.hi;
        lo <= res_q.lo;
      end
    end else if (accept && op == OP_MTHI) begin
      hi <= rs_data;
    end else if (accept && op == OP_MTLO) begin
      lo <= rs_data;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: a default instance and a MULT_CYCLES=1/DIV_CYCLES=31 instance.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start [2];
  logic [2:0]  op    [2];
  logic [31:0] rs    [2];
  logic [31:0] rt    [2];
  logic        busy  [2];
  logic [31:0] dhi   [2];
  logic [31:0] dlo   [2];

  always #5 clk = ~clk;

  muldiv_unit u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .op(op[0]),
    .rs_data(rs[0]), .rt_data(rt[0]), .busy(busy[0]), .hi(dhi[0]), .lo(dlo[0])
  );

  muldiv_unit #(.MULT_CYCLES(1), .DIV_CYCLES(31)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .op(op[1]),
    .rs_data(rs[1]), .rt_data(rt[1]), .busy(busy[1]), .hi(dhi[1]), .lo(dlo[1])
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sh_hi [2];
  logic [31:0] sh_lo [2];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference model: 64-bit arithmetic, no magnitude tricks.
  task automatic model(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint          sp, sa, sb64, q, r;
    longint unsigned up;
    e.hi  = sh_hi[s];
    e.lo  = sh_lo[s];
    e.cyc = 0;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32]; e.lo = sp[31:0]; e.cyc = s ? 1 : 5;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        e.hi = up[63:32]; e.lo = up[31:0]; e.cyc = s ? 1 : 5;
      end
      3'd2: begin
        e.cyc = s ? 31 : 10;
        if (b != 0) begin
          sa = longint'($signed(a)); sb64 = longint'($signed(b));
          q = sa / sb64; r = sa % sb64;
          e.hi = r[31:0]; e.lo = q[31:0];
        end
      end
      3'd3: begin
        e.cyc = s ? 31 : 10;
        if (b != 0) begin
          e.hi = a % b; e.lo = a / b;
        end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    e.tag = $sformatf("u%0d op%0d %h,%h", s, o, a, b);
  endtask

  // Drive at #1 after an edge; count busy cycles; compare on completion.
  // poke: re-request MTHI during RUN and on the edge where busy falls.
  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit poke = 1'b0);
    exp_t e;
    int   cyc;
    model(s, o, a, b, e);
    sb.push_back(e);
    sh_hi[s] = e.hi;
    sh_lo[s] = e.lo;
    start[s] = 1'b1; op[s] = o; rs[s] = a; rt[s] = b;
    @(posedge clk); #1;
    start[s] = 1'b0; rs[s] = $urandom; rt[s] = $urandom;
    cyc = 0;
    while (busy[s] && cyc < 64) begin
      cyc++;
      if (poke && (cyc == 2 || cyc == e.cyc)) begin
        start[s] = 1'b1; op[s] = 3'b100; rs[s] = 32'hDEADBEEF;
      end else begin
        start[s] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start[s] = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " cycles"}, 32'(cyc), 32'(e.cyc));
    chk({e.tag, " hi"}, dhi[s], e.hi);
    chk({e.tag, " lo"}, dlo[s], e.lo);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; op[i] = '0; rs[i] = '0; rt[i] = '0;
      sh_hi[i] = '0; sh_lo[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset hi", dhi[0], 32'd0);
    chk("reset lo", dlo[0], 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult -2*3 hi", dhi[0], 32'hFFFFFFFF);
    chk("mult -2*3 lo", dlo[0], 32'hFFFFFFFA);
    run_op(0, 3'd1, 32'hFFFFFFFE, 32'd3);
    chk("multu hi", dhi[0], 32'h00000002);
    chk("multu lo", dlo[0], 32'hFFFFFFFA);
    run_op(0, 3'd2, 32'hFFFFFFF9, 32'd2);
    chk("div -7/2 lo", dlo[0], 32'hFFFFFFFD);
    chk("div -7/2 hi", dhi[0], 32'hFFFFFFFF);
    run_op(0, 3'd3, 32'hFFFFFFF9, 32'd2);
    chk("divu lo", dlo[0], 32'h7FFFFFFC);
    chk("divu hi", dhi[0], 32'h00000001);
    run_op(0, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("div ovf lo", dlo[0], 32'h80000000);
    chk("div ovf hi", dhi[0], 32'h00000000);

    run_op(0, 3'd4, 32'h11111111, 32'd0);
    run_op(0, 3'd5, 32'h22222222, 32'd0);
    run_op(0, 3'd2, 32'd1234, 32'd0);
    chk("div0 hi", dhi[0], 32'h11111111);
    chk("div0 lo", dlo[0], 32'h22222222);
    run_op(0, 3'd3, 32'd5, 32'd0);
    run_op(0, 3'd6, 32'h0BADF00D, 32'd1);
    run_op(0, 3'd7, 32'h0BADF00D, 32'd1);

    run_op(0, 3'd0, 32'd3, 32'd4, 1'b1);
    chk("ignored start hi", dhi[0], 32'd0);
    chk("ignored start lo", dlo[0], 32'd12);
    run_op(0, 3'd4, 32'hA5A5A5A5, 32'd0);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i % 5 == 1) rb = rb >> 20;
      run_op(0, ro, ra, rb);
    end

    run_op(0, 3'd4, 32'd3, 32'd0);
    run_op(0, 3'd5, 32'd4, 32'd0);
    start[0] = 1'b1; op[0] = 3'd2; rs[0] = 32'd100; rt[0] = 32'd7;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy[0]), 32'd0);
    chk("async rst hi", dhi[0], 32'd0);
    chk("async rst lo", dlo[0], 32'd0);
    for (int i = 0; i < 2; i++) begin sh_hi[i] = '0; sh_lo[i] = '0; end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post rst no commit lo", dlo[0], 32'd0);
    run_op(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu max hi", dhi[0], 32'hFFFFFFFE);
    chk("multu max lo", dlo[0], 32'h00000001);

    run_op(1, 3'd0, 32'hFFFFFFFE, 32'd3);
    chk("sweep mult hi", dhi[1], 32'hFFFFFFFF);
    chk("sweep mult lo", dlo[1], 32'hFFFFFFFA);
    run_op(1, 3'd2, 32'hFFFFFFF9, 32'd2);
    chk("sweep div lo", dlo[1], 32'hFFFFFFFD);
    chk("sweep div hi", dhi[1], 32'hFFFFFFFF);
    run_op(1, 3'd3, 32'hFFFFFFF9, 32'd2);
    run_op(1, 3'd1, 32'hFFFFFFFE, 32'd3);
    run_op(1, 3'd2, 32'h80000000, 32'hFFFFFFFF);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS datapath. It accepts operands from the register-read stage, after the forwarding multiplexers, and runs MULT/MULTU/DIV/DIVU over a fixed number of cycles. HI/LO results feed the writeback-data selection multiplexer (MFHI/MFLO path). `busy` drives the hazard unit's stall logic.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU; legal range 1..31.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU; legal range 1..31.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled on the rising edge.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved and act as a no-op.
- `rs_data`  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
- `rt_data`  in  32  operand B: multiplier or divisor.
- `busy`  out  1  high while a multiply/divide is in flight.
- `hi`  out  32  HI register value.
- `lo`  out  32  LO register value.

## Operation

- States:
  - IDLE: counter = 0, `busy` = 0.
  - RUN: counter > 0, `busy` = 1.
- A request is accepted on a rising edge where `start`=1 and the unit is in IDLE.
  - `start` while in RUN is ignored entirely: no state or register change. The hazard unit must stall instead.
- MULT/MULTU/DIV/DIVU on accept:
  - Operands are latched internally; later changes on `rs_data`/`rt_data` have no effect.
  - The result is computed into internal temp registers.
  - The counter loads `MULT_CYCLES` or `DIV_CYCLES`; the state becomes RUN.
- RUN:
  - The counter decrements every edge.
  - On the edge where the counter goes 1→0, temp HI/LO are copied to `hi`/`lo` and the state returns to IDLE.
- MTHI/MTLO on accept:
  - `hi` (respectively `lo`) is loaded with `rs_data` on the same edge.
  - The other register is unchanged; `busy` stays 0.
- Arithmetic rules:
  - MULT: signed 32x32→64. `hi` = bits [63:32], `lo` = bits [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed. `lo` = quotient, truncated toward zero. `hi` = remainder, with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0x00000000.
  - DIVU: unsigned quotient in `lo`, remainder in `hi`.
  - Divisor 0 (DIV or DIVU): the full `DIV_CYCLES` busy period still runs. At completion `hi`/`lo` keep their previous values.
- Reserved op with `start`=1: no state change, `busy` stays 0.
- Reset (`reset_n`=0, at any time, including mid-RUN):
  - `busy`=0, `hi`=0, `lo`=0, counter=0, temps=0.
  - Any in-flight operation is discarded.
- While `reset_n`=0, all inputs are ignored.

## Timing

- Accept at edge k:
  - `busy` is 1 from just after edge k through edge k+N−1, where N is the selected cycle count.
  - `busy` falls and `hi`/`lo` take the new values just after edge k+N.
- `hi`/`lo` hold their old values during RUN. MFHI/MFLO issued during RUN must be stalled by the hazard unit; this block does not block reads.
- Back-to-back: a new `start` at edge k+N (the same edge `busy` falls) is rejected. The earliest accept is edge k+N+1, i.e. the first edge at which `busy` is sampled 0.
- MTHI/MTLO latency is 1 edge; the value is visible after that edge.
- `busy`, `hi`, `lo` are registered outputs with no combinational path from inputs.
- Reset assertion clears outputs immediately, without waiting for `clk`. Deassertion takes effect at the first rising edge after `reset_n` rises.

## Test plan

- Reset then MULT: reset, then MULT with `rs_data`=0xFFFFFFFE (−2), `rt_data`=0x00000003.
  - Expected: `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - MULTU with the same operands: `hi`=0x00000002, `lo`=0xFFFFFFFA.
- Signed and unsigned divide:
  - DIV −7 / 2: after 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2: `lo`=0x7FFFFFFC, `hi`=1.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Divide by zero with preset registers:
  - Set `hi`=0x11111111 via MTHI and `lo`=0x22222222 via MTLO, then DIV x/0.
  - Expected: `busy` high 10 cycles; `hi`/`lo` still 0x11111111/0x22222222 after completion.
- Ignored start and operand latching:
  - MULT 3×4, then during RUN pulse `start` with MTHI 0xDEADBEEF and change the operands.
  - Expected: `busy` length unchanged, final `hi`=0, `lo`=12, no MTHI effect.
  - MTHI accepted at the first edge with `busy`=0.
- Reset mid-operation: assert `reset_n`=0 asynchronously during cycle 3 of a DIV.
  - Expected: `busy`, `hi`, `lo` go to 0 immediately.
  - After release, a new MULTU 0xFFFFFFFF×0xFFFFFFFF gives `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Parameter sweep: `MULT_CYCLES`=1, `DIV_CYCLES`=31.
  - Expected: `busy` pulse widths of 1 and 31 cycles; results identical to the defaults.
